// File: rtl/bound_flasher_monitor_if.sv
// Observation bus between the bound flasher and its monitor.
// The flasher drives LED/FLICK through the master modport. The monitor reads them through the slave modport.
interface bound_flasher_monitor_if;
  logic [15:0] LED;
  logic        FLICK;

  modport master (output LED, output FLICK);
  modport slave  (input  LED, input  FLICK);
endinterface

// File: rtl/bound_flasher_monitor.sv
// Passive checker for the bound flasher thermometer bus.
// Decodes the bar level and checks every step against the three-phase bound sequence.
//
// state | meaning
// IDLE  | bar dark, waiting for the first LED
// UP    | bar growing toward the phase upper bound
// DOWN  | bar shrinking toward the phase lower bound
// SYNC  | after reset or an error, waiting for LED==0
module bound_flasher_monitor #(
  parameter int P0_MAX = 16,
  parameter int P0_MIN = 6,
  parameter int P1_MAX = 11,
  parameter int P1_MIN = 1,
  parameter int P2_MAX = 6,
  parameter int P2_MIN = 1,
  parameter int KB_LO  = 1,
  parameter int KB_HI  = 6,
  parameter int CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  bound_flasher_monitor_if.slave bus,
  output logic [4:0]            LEVEL,
  output logic [1:0]            DIR,
  output logic [1:0]            PHASE,
  output logic                  CYCLE_DONE,
  output logic [CNT_W-1:0]      CYCLE_CNT,
  output logic                  ERR,
  output logic [2:0]            ERR_CODE,
  output logic [CNT_W-1:0]      ERR_CNT
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, SYNC = 2'd3} state_t;

  localparam logic [2:0] E_NOT_THERMO = 3'd1;
  localparam logic [2:0] E_BAD_STEP   = 3'd2;
  localparam logic [2:0] E_BOUND      = 3'd3;
  localparam logic [2:0] E_STALL      = 3'd4;

  state_t     state, nxt_state;
  logic [1:0] phase, nxt_phase;
  logic [4:0] n, p, b_max, b_min;
  logic       thermo, kick, err_hit, done_hit;
  logic [2:0] err_code_nxt;

  assign p = LEVEL;

  always_comb begin
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + 5'(bus.LED[i]);
  end

  // A thermometer code is 2^k-1, so adding one clears every set bit.
  assign thermo = ((bus.LED & (bus.LED + 16'd1)) == 16'd0);

  always_comb begin
    case (phase)
      2'd0:    begin b_max = 5'(P0_MAX); b_min = 5'(P0_MIN); end
      2'd1:    begin b_max = 5'(P1_MAX); b_min = 5'(P1_MIN); end
      default: begin b_max = 5'(P2_MAX); b_min = 5'(P2_MIN); end
    endcase
  end

  assign kick = bus.FLICK && (p == 5'(KB_LO) || p == 5'(KB_HI)) && (n == p + 5'd1);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= SYNC;
      phase      <= 2'd0;
      LEVEL      <= 5'd0;
      CYCLE_DONE <= 1'b0;
      CYCLE_CNT  <= '0;
      ERR        <= 1'b0;
      ERR_CODE   <= 3'd0;
      ERR_CNT    <= '0;
    end else begin
      state      <= nxt_state;
      phase      <= nxt_phase;
      CYCLE_DONE <= done_hit;
      if (thermo) LEVEL <= n;
      if (done_hit) CYCLE_CNT <= CYCLE_CNT + 1'b1;
      if (err_hit) begin
        ERR <= 1'b1;
        if (ERR_CODE == 3'd0) ERR_CODE <= err_code_nxt;
        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_phase    = phase;
    err_hit      = 1'b0;
    err_code_nxt = 3'd0;
    done_hit     = 1'b0;
    if (state == SYNC) begin
      if (bus.LED == 16'd0) nxt_state = IDLE;
    end else if (!thermo) begin
      err_hit      = 1'b1;
      err_code_nxt = E_NOT_THERMO;
    end else begin
      case (state)
        IDLE: begin
          if (n == 5'd1) begin
            nxt_state = UP;
            nxt_phase = 2'd0;
          end else if (n != 5'd0) begin
            err_hit      = 1'b1;
            err_code_nxt = E_BAD_STEP;
          end
        end
        UP: begin
          if (p < b_max && n == p + 5'd1) begin
            nxt_state = UP;
          end else if (p == b_max && n == p - 5'd1) begin
            nxt_state = DOWN;
          end else begin
            err_hit      = 1'b1;
            err_code_nxt = (n == p) ? E_STALL : (n > b_max) ? E_BOUND : E_BAD_STEP;
          end
        end
        DOWN: begin
          // A flick at a kick-back level overrides the normal phase advance.
          if (kick) begin
            nxt_state = UP;
            nxt_phase = (phase == 2'd0) ? 2'd0 : phase - 2'd1;
          end else if (p != b_min && n == p - 5'd1) begin
            nxt_state = DOWN;
          end else if (p == b_min && phase < 2'd2 && n == p + 5'd1) begin
            nxt_state = UP;
            nxt_phase = phase + 2'd1;
          end else if (p == b_min && phase == 2'd2 && n == 5'd0) begin
            nxt_state = IDLE;
            nxt_phase = 2'd0;
            done_hit  = 1'b1;
          end else begin
            err_hit      = 1'b1;
            err_code_nxt = (n == p) ? E_STALL : (n < b_min) ? E_BOUND : E_BAD_STEP;
          end
        end
        default: nxt_state = SYNC;
      endcase
    end
    if (err_hit) nxt_state = SYNC;
  end

  always_comb begin
    DIR   = state;
    PHASE = phase;
  end

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Scoreboard bench for bound_flasher_monitor: each driven sample queues its expected outputs.
// The expectations are popped and compared one cycle later.
module tb_bound_flasher_monitor;
  localparam int D_IDLE = 0, D_UP = 1, D_DOWN = 2, D_SYNC = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] LEVEL;
  logic [1:0] DIR, PHASE;
  logic       CYCLE_DONE, ERR;
  logic [7:0] CYCLE_CNT, ERR_CNT;
  logic [2:0] ERR_CODE;

  bound_flasher_monitor_if bus();

  bound_flasher_monitor dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave),
    .LEVEL(LEVEL), .DIR(DIR), .PHASE(PHASE), .CYCLE_DONE(CYCLE_DONE),
    .CYCLE_CNT(CYCLE_CNT), .ERR(ERR), .ERR_CODE(ERR_CODE), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int lvl; int dir; int ph; int done; int cyc; int err; int code; int ecnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int e_cyc = 0, e_err = 0, e_code = 0, e_ecnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] therm(input int n);
    logic [16:0] v;
    v = (17'd1 << n) - 17'd1;
    return v[15:0];
  endfunction

  task automatic drv(input logic [15:0] led, input logic flick, input int lvl,
                     input int dir, input int ph, input int done);
    exp_t e;
    @(negedge CLK);
    bus.LED   = led;
    bus.FLICK = flick;
    e = '{lvl: lvl, dir: dir, ph: ph, done: done, cyc: e_cyc,
          err: e_err, code: e_code, ecnt: e_ecnt};
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("level", int'(LEVEL), e.lvl);
    chk("dir", int'(DIR), e.dir);
    chk("phase", int'(PHASE), e.ph);
    chk("cycle_done", int'(CYCLE_DONE), e.done);
    chk("cycle_cnt", int'(CYCLE_CNT), e.cyc);
    chk("err", int'(ERR), e.err);
    chk("err_code", int'(ERR_CODE), e.code);
    chk("err_cnt", int'(ERR_CNT), e.ecnt);
  endtask

  task automatic up_run(input int a, input int b, input int ph);
    for (int n = a; n <= b; n++) drv(therm(n), 1'b0, n, D_UP, ph, 0);
  endtask

  task automatic down_run(input int a, input int b, input int ph);
    for (int n = a; n >= b; n--) drv(therm(n), 1'b0, n, D_DOWN, ph, 0);
  endtask

  task automatic legal_seq();
    up_run(1, 16, 0);
    down_run(15, 6, 0);
    up_run(7, 11, 1);
    down_run(10, 1, 1);
    up_run(2, 6, 2);
    down_run(5, 1, 2);
    e_cyc++;
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 1);
  endtask

  task automatic do_reset(input logic [15:0] led, input logic flick);
    RST = 1'b0;
    e_cyc = 0; e_err = 0; e_code = 0; e_ecnt = 0;
    drv(led, flick, 0, D_SYNC, 0, 0);
    RST = 1'b1;
  endtask

  initial begin
    bus.LED   = 16'h0000;
    bus.FLICK = 1'b0;

    do_reset(16'h0000, 1'b0);
    repeat (3) drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);

    legal_seq();
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);

    // Kick-back at the phase-0 lower bound, then a broken thermometer code.
    up_run(1, 16, 0);
    down_run(15, 7, 0);
    drv(therm(6), 1'b1, 6, D_DOWN, 0, 0);
    drv(therm(7), 1'b1, 7, D_UP, 0, 0);
    e_err = 1; e_code = 1; e_ecnt = 1;
    drv(16'h0005, 1'b0, 7, D_SYNC, 0, 0);
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);

    // A stall records its code first; a later overshoot is only counted.
    do_reset(16'h0000, 1'b0);
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);
    up_run(1, 8, 0);
    e_err = 1; e_code = 4; e_ecnt = 1;
    drv(16'h00FF, 1'b0, 8, D_SYNC, 0, 0);
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);
    up_run(1, 16, 0);
    down_run(15, 6, 0);
    up_run(7, 10, 1);
    e_ecnt = 2;
    drv(16'h0FFF, 1'b0, 12, D_SYNC, 1, 0);

    // Reset in the middle of a falling bar, then a clean sequence.
    do_reset(16'h0000, 1'b0);
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);
    up_run(1, 16, 0);
    down_run(15, 9, 0);
    do_reset(therm(9), 1'b0);
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);
    legal_seq();
    drv(16'h0000, 1'b0, 0, D_IDLE, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
